// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and default widths for the memory arbiter.
// Revision 1.0
`default_nettype none

package mem_arb_pkg;

  localparam int ADDR_W_DEF = 30;
  localparam int LINE_W_DEF = 256;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } gnt_t;

endpackage

`default_nettype wire

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: winner selection between I and D ports; round-robin pointer
// only when MEM_ARB_RR_EN is defined, otherwise fixed D-first priority. Rev 1.0
`default_nettype none

module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic ireq_i,
  input  logic dreq_i,
  input  logic grant_i,
  output gnt_t gnt_o
);

`ifdef MEM_ARB_RR_EN
  gnt_t ptr_q, ptr_d;

  // ptr_q names the port that wins the next tie.
  always_comb begin
    gnt_o = ptr_q;
    if (ireq_i && !dreq_i) begin
      gnt_o = GNT_I;
    end else if (dreq_i && !ireq_i) begin
      gnt_o = GNT_D;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (grant_i) begin
      ptr_d = (gnt_o == GNT_I) ? GNT_D : GNT_I;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= GNT_I;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  logic unused_w;

  always_comb begin
    gnt_o = dreq_i ? GNT_D : GNT_I;
  end

  assign unused_w = clk ^ rst_n ^ grant_i;
`endif

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (I/D) line-memory arbiter with a fixed-latency RAM
// interface. Optional round-robin arbitration via MEM_ARB_RR_EN. Rev 1.0
`default_nettype none

module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int LINE_W  = LINE_W_DEF,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_done,
  output logic [LINE_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic              d_done,
  output logic [LINE_W-1:0] d_rdata,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_wdata_o,
  input  logic [LINE_W-1:0] mem_block_i,
  output logic              busy_o
);

  localparam logic [2:0] LAST_CNT = 3'(MEM_LAT - 1);

  state_t              state_q, state_d;
  logic [2:0]          cnt_q, cnt_d;
  gnt_t                gnt_q, gnt_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LINE_W-1:0]   wdata_q, wdata_d;
  logic [LINE_W-1:0]   i_rdata_q, i_rdata_d;
  logic [LINE_W-1:0]   d_rdata_q, d_rdata_d;
  gnt_t                pick_w;
  logic                grant_w;

  assign grant_w = (state_q == IDLE) && (i_req || d_req);

  mem_arb_pick u_pick (
    .clk     (clk),
    .rst_n   (rst_n),
    .ireq_i  (i_req),
    .dreq_i  (d_req),
    .grant_i (grant_w),
    .gnt_o   (pick_w)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    gnt_d     = gnt_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    case (state_q)
      IDLE: begin
        if (grant_w) begin
          state_d = ISSUE;
          gnt_d   = pick_w;
          if (pick_w == GNT_D) begin
            we_d    = d_we;
            addr_d  = d_addr;
            wdata_d = d_wdata;
          end else begin
            we_d    = 1'b0;
            addr_d  = i_addr;
            wdata_d = '0;
          end
        end
      end
      ISSUE: begin
        state_d = WAIT;
        cnt_d   = 3'd0;
      end
      WAIT: begin
        if (cnt_q == LAST_CNT) begin
          state_d = RESP;
          cnt_d   = 3'd0;
          // The RAM output is registered, so it is stable by the last WAIT cycle.
          if (!we_q) begin
            if (gnt_q == GNT_D) begin
              d_rdata_d = mem_block_i;
            end else begin
              i_rdata_d = mem_block_i;
            end
          end
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= 3'd0;
      gnt_q     <= GNT_I;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      gnt_q     <= gnt_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  // All outputs decode registered state only, so they move only on clk or reset.
  assign mem_en_o    = (state_q == ISSUE);
  assign mem_we_o    = (state_q == ISSUE) && we_q;
  assign mem_addr_o  = (state_q == ISSUE) ? addr_q : '0;
  assign mem_wdata_o = (state_q == ISSUE) ? wdata_q : '0;
  assign i_done      = (state_q == RESP) && (gnt_q == GNT_I);
  assign d_done      = (state_q == RESP) && (gnt_q == GNT_D);
  assign i_rdata     = i_rdata_q;
  assign d_rdata     = d_rdata_q;
  assign busy_o      = (state_q != IDLE);

endmodule

`default_nettype wire
